dma_wr_burst_master: RTL and testbench
======================================

DMA_WR_BURST_MASTER -- requirements
Module: dma_wr_burst_master

Interface
REQ-001 Parameter DW, default 32, Avalon data width in bits; a multiple of 8.
REQ-002 Parameter AW, default 32, Avalon byte-address width.
REQ-003 Parameter LW, default 16, transfer-length width in words.
REQ-004 Parameter MAXB, default 16, maximum burst length in words; a power of 2, at least 1.
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 clr_n  in  1  synchronous clear, active-low; aborts any transfer.
REQ-008 start  in  1  one-cycle command strobe; accepted only when busy=0.
REQ-009 addr  in  AW  start byte address; word aligned (low log2(DW/8) bits ignored).
REQ-010 len  in  LW  transfer length in words.
REQ-011 busy  out  1  command in progress.
REQ-012 done  out  1  one-cycle pulse at transfer completion.
REQ-013 fifo_ne  in  1  upstream FIFO not empty.
REQ-014 fifo_q  in  DW  upstream FIFO head word.
REQ-015 fifo_re  out  1  pop strobe to the upstream FIFO.
REQ-016 avm_address  out  AW  Avalon-MM burst start byte address.
REQ-017 avm_burstcount  out  log2(MAXB)+1  Avalon burst length in words.
REQ-018 avm_write  out  1  Avalon write request.
REQ-019 avm_writedata  out  DW  Avalon write data; equals fifo_q combinationally.
REQ-020 avm_byteenable  out  DW/8  all ones.
REQ-021 avm_waitrequest  in  1  Avalon slave stall.

Function
REQ-022 The FSM SHALL have three states: IDLE, CALC and BURST.
REQ-023 IDLE: start=1 with len!=0 latches the word address and remaining=len, then moves to CALC; start=1 with len=0 pulses done on the next cycle and stays in IDLE.
REQ-024 CALC: bc = min(remaining, MAXB - (word address mod MAXB)), so no burst crosses a MAXB-word-aligned boundary; bc is registered to avm_burstcount, the byte address to avm_address and bc to a beat counter; next state is BURST. CALC takes exactly one cycle.
REQ-025 BURST: avm_write = fifo_ne.
REQ-026 BURST: fifo_re = fifo_ne & ~avm_waitrequest.
REQ-027 BURST, each beat with fifo_re=1: the beat counter decrements, remaining decrements and the word address increments.
REQ-028 A FIFO-empty gap mid-burst only deasserts avm_write; avm_address and avm_burstcount stay constant for the whole burst.
REQ-029 The last beat of a burst (beat counter=1 and fifo_re=1) goes to CALC if remaining>1.
REQ-030 The last beat of a burst with remaining=1 returns to IDLE and asserts done on the next cycle.
REQ-031 busy=1 in CALC and BURST and 0 in IDLE; start while busy=1 is ignored.
REQ-032 fifo_re and avm_write SHALL never be asserted outside BURST.
REQ-033 The address increments modulo 2^AW (wrap permitted); remaining and the beat counter never underflow.
REQ-034 Per-burst overhead is one CALC cycle; with no stalls, throughput is bc/(bc+1) words/cycle.
REQ-035 Completion latency equals beats + bursts + 1 cycles from start, excluding stall cycles.

Reset
REQ-036 rst_n=0 immediately forces IDLE with busy=0, done=0, avm_write=0, fifo_re=0, avm_address=0, avm_burstcount=0 and the counters at 0.
REQ-037 clr_n=0 at a clock edge produces the same state as rst_n, even mid-burst; done is not pulsed; the Avalon burst is abandoned; the FIFO contents are not touched.

Structure
REQ-038 The FSM state encodings and the burstcount width function clog2 SHALL live in a shared package dma_wr_pkg.
REQ-039 The boundary/min calculation SHALL be a single sub-module dma_wr_burst_calc, purely combinational with inputs word address, remaining and MAXB and output bc.
REQ-040 There SHALL be no other sub-modules; the upstream FIFO is external.

Verification
REQ-041 addr=0x0, len=16, MAXB=16, FIFO always non-empty, no stalls -> one burst of burstcount=16 at 0x0; done 18 cycles after start.
REQ-042 addr=0x38, len=20, DW=32 -> bursts of 2 at 0x38, 16 at 0x40 and 2 at 0x80; 20 pops total; one done.
REQ-043 len=5, avm_waitrequest high on beats 2-3 and fifo_ne low for 2 cycles mid-burst -> address/burstcount stable; exactly 5 pops; data order preserved.
REQ-044 start with len=0 -> done one cycle later; no avm_write; busy stays 0.
REQ-045 clr_n pulsed low mid-burst after 3 of 8 beats -> busy=0, avm_write=0 next cycle; no done; a new start then works normally.
REQ-046 start while busy -> ignored; the transfer in progress is unchanged.

Source files
------------

// File: rtl/dma_wr_pkg.sv
// Shared definitions for the DMA write burst master: FSM encodings and the
// width helper used to size the Avalon burstcount.
package dma_wr_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    // Smallest r with 2**r >= value; clog2(1) = 0, so MAXB=1 yields a 1-bit burstcount.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/dma_wr_burst_calc.sv
// Burst length calculator: the largest burst that fits in the remaining length
// without crossing a MAXB-word-aligned boundary.
module dma_wr_burst_calc
    import dma_wr_pkg::*;
#(
    parameter int AW   = 32,
    parameter int LW   = 16,
    parameter int MAXB = 16
) (
    input  logic [AW-1:0]          word_addr,
    input  logic [LW-1:0]          remaining,
    output logic [clog2(MAXB):0]   bc
);

    localparam int BCW = clog2(MAXB) + 1;
    localparam int CW  = (LW > BCW) ? LW : BCW;

    logic [BCW-1:0] offset;
    logic [BCW-1:0] room;
    logic [CW-1:0]  rem_x;
    logic [CW-1:0]  room_x;

    // NOTE: every signal written here is assigned on every path, so no latch can be inferred.
    always_comb begin
        offset = BCW'(word_addr & AW'(MAXB - 1));
        room   = BCW'(MAXB) - offset;
        rem_x  = CW'(remaining);
        room_x = CW'(room);
        bc     = (rem_x < room_x) ? BCW'(remaining) : room;
    end

endmodule

// File: rtl/dma_wr_burst_master.sv
// Avalon-MM write burst master: drains an external FIFO into bursts that never
// cross a MAXB-word boundary, one CALC cycle of overhead per burst.
module dma_wr_burst_master
    import dma_wr_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int LW   = 16,
    parameter int MAXB = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic [AW-1:0]         addr,
    input  logic [LW-1:0]         len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_ne,
    input  logic [DW-1:0]         fifo_q,
    output logic                  fifo_re,
    output logic [AW-1:0]         avm_address,
    output logic [clog2(MAXB):0]  avm_burstcount,
    output logic                  avm_write,
    output logic [DW-1:0]         avm_writedata,
    output logic [DW/8-1:0]       avm_byteenable,
    input  logic                  avm_waitrequest
);

    localparam int BCW = clog2(MAXB) + 1;
    localparam int OFS = clog2(DW / 8);

    logic [1:0]     state;
    logic [AW-1:0]  word_addr;
    logic [LW-1:0]  remaining;
    logic [BCW-1:0] beats;
    logic [BCW-1:0] bc;

    dma_wr_burst_calc #(
        .AW   (AW),
        .LW   (LW),
        .MAXB (MAXB)
    ) u_calc (
        .word_addr (word_addr),
        .remaining (remaining),
        .bc        (bc)
    );

    // A synchronous clear also suppresses the pop on its own edge, so the FIFO is left untouched.
    assign busy           = (state != ST_IDLE);
    assign avm_write      = (state == ST_BURST) && fifo_ne && clr_n;
    assign fifo_re        = avm_write && !avm_waitrequest;
    assign avm_writedata  = fifo_q;
    assign avm_byteenable = '1;

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            word_addr      <= '0;
            remaining      <= '0;
            beats          <= '0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            done           <= 1'b0;
        end else if (!clr_n) begin
            state          <= ST_IDLE;
            word_addr      <= '0;
            remaining      <= '0;
            beats          <= '0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            word_addr <= addr >> OFS;
                            remaining <= len;
                            state     <= ST_CALC;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    avm_burstcount <= bc;
                    avm_address    <= word_addr << OFS;
                    beats          <= bc;
                    state          <= ST_BURST;
                end
                ST_BURST: begin
                    if (fifo_re) begin
                        word_addr <= word_addr + 1'b1;
                        if (remaining != '0) begin
                            remaining <= remaining - 1'b1;
                        end
                        if (beats != '0) begin
                            beats <= beats - 1'b1;
                        end
                        if (beats == BCW'(1)) begin
                            if (remaining > LW'(1)) begin
                                state <= ST_CALC;
                            end else begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_wr_burst_master.sv
// Directed bench for dma_wr_burst_master: a table of transfers with hand-computed
// bursts and latencies, plus hand-written reset and mid-burst clear sequences.
module tb_dma_wr_burst_master;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int LW   = 16;
    localparam int MAXB = 16;
    localparam int NV   = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clr_n = 1'b1;
    logic           start = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic [LW-1:0]  len = '0;
    logic           busy;
    logic           done;
    logic           fifo_ne = 1'b0;
    logic [DW-1:0]  fifo_q;
    logic           fifo_re;
    logic [AW-1:0]  avm_address;
    logic [4:0]     avm_burstcount;
    logic           avm_write;
    logic [DW-1:0]  avm_writedata;
    logic [3:0]     avm_byteenable;
    logic           avm_waitrequest = 1'b0;

    dma_wr_burst_master #(
        .DW   (DW),
        .AW   (AW),
        .LW   (LW),
        .MAXB (MAXB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clr_n           (clr_n),
        .start           (start),
        .addr            (addr),
        .len             (len),
        .busy            (busy),
        .done            (done),
        .fifo_ne         (fifo_ne),
        .fifo_q          (fifo_q),
        .fifo_re         (fifo_re),
        .avm_address     (avm_address),
        .avm_burstcount  (avm_burstcount),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: an endless sequence of numbered words, advanced on each pop.
    logic [31:0] fifo_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fifo_cnt <= '0;
        else if (fifo_re) fifo_cnt <= fifo_cnt + 1;
    end
    assign fifo_q = 32'hA500_0000 + fifo_cnt;

    int errors = 0;
    int checks = 0;
    int pop_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0]      addr;
        logic [15:0]      len;
        int               lat;
        int               nb;
        logic [2:0][31:0] ba;
        logic [2:0][4:0]  bc;
        int               poke;
        logic [63:0]      wmask;
        logic [63:0]      emask;
    } vec_t;

    function automatic vec_t mkv(
        input logic [31:0] a, input logic [15:0] l, input int lat, input int nb,
        input logic [31:0] ba0, input logic [4:0] bc0,
        input logic [31:0] ba1, input logic [4:0] bc1,
        input logic [31:0] ba2, input logic [4:0] bc2,
        input int poke, input logic [63:0] wm, input logic [63:0] em);
        vec_t v;
        v.addr  = a;
        v.len   = l;
        v.lat   = lat;
        v.nb    = nb;
        v.ba[0] = ba0; v.bc[0] = bc0;
        v.ba[1] = ba1; v.bc[1] = bc1;
        v.ba[2] = ba2; v.bc[2] = bc2;
        v.poke  = poke;
        v.wmask = wm;
        v.emask = em;
        return v;
    endfunction

    vec_t vecs[NV];

    // One transfer; sampling happens 1 time unit after each falling edge, i.e. before the next rising edge.
    task automatic run(input vec_t v, input int id);
        int beat;
        int lat;
        int j;
        int cum;
        logic busy_seen;
        beat = 0;
        lat = 0;
        busy_seen = 1'b0;
        @(negedge clk);
        addr  = v.addr;
        len   = v.len;
        start = 1'b1;
        for (int c = 1; c <= 200 && lat == 0; c++) begin
            fifo_ne         = (c < 64) ? !v.emask[c] : 1'b1;
            avm_waitrequest = (c < 64) ? v.wmask[c] : 1'b0;
            if (v.poke == c) begin
                start = 1'b1;
                addr  = 32'h0000_0800;
                len   = 16'd7;
            end
            #1;
            busy_seen = busy_seen | busy;
            if (!fifo_ne) check($sformatf("v%0d_write_gated", id), avm_write, 1'b0);
            if (avm_write) begin
                j = v.nb;
                cum = 0;
                for (int k = 0; k < v.nb; k++) begin
                    if (j == v.nb && beat < cum + int'(v.bc[k])) j = k;
                    cum += int'(v.bc[k]);
                end
                if (j >= v.nb) begin
                    check($sformatf("v%0d_beat_in_range", id), beat < int'(v.len), 1'b1);
                end else begin
                    check($sformatf("v%0d_avm_address", id), avm_address, v.ba[j]);
                    check($sformatf("v%0d_avm_burstcount", id), avm_burstcount, v.bc[j]);
                end
                if (fifo_re) begin
                    check($sformatf("v%0d_writedata", id), avm_writedata, 32'hA500_0000 + pop_idx);
                    pop_idx++;
                    beat++;
                end
            end else begin
                check($sformatf("v%0d_pop_gated", id), fifo_re, 1'b0);
            end
            @(negedge clk);
            start = 1'b0;
            if (done) lat = c;
        end
        fifo_ne         = 1'b1;
        avm_waitrequest = 1'b0;
        check($sformatf("v%0d_done_seen", id), lat != 0, 1'b1);
        check($sformatf("v%0d_latency", id), lat, v.lat);
        check($sformatf("v%0d_pops", id), beat, v.len);
        check($sformatf("v%0d_busy_seen", id), busy_seen, v.len != 0);
        #1;
        check($sformatf("v%0d_busy_after_done", id), busy, 1'b0);
        @(negedge clk);
        check($sformatf("v%0d_done_one_cycle", id), done, 1'b0);
    endtask

    initial begin
        int pops;
        //            addr          len  lat nb  burst0          burst1          burst2         poke wmask   emask
        vecs[0] = mkv(32'h0000_0000, 16, 18, 1, 32'h0000_0000, 16, 32'h0, 0,        32'h0, 0,        0, 64'h0,  64'h0);
        vecs[1] = mkv(32'h0000_0038, 20, 24, 3, 32'h0000_0038, 2,  32'h0000_0040, 16, 32'h0000_0080, 2, 0, 64'h0,  64'h0);
        vecs[2] = mkv(32'h0000_0100, 1,  3,  1, 32'h0000_0100, 1,  32'h0, 0,        32'h0, 0,        0, 64'h0,  64'h0);
        vecs[3] = mkv(32'h0000_003C, 3,  6,  2, 32'h0000_003C, 1,  32'h0000_0040, 2,  32'h0, 0,        0, 64'h0,  64'h0);
        vecs[4] = mkv(32'hFFFF_FFF8, 4,  7,  2, 32'hFFFF_FFF8, 2,  32'h0000_0000, 2,  32'h0, 0,        0, 64'h0,  64'h0);
        vecs[5] = mkv(32'h0000_0043, 17, 20, 2, 32'h0000_0040, 16, 32'h0000_0080, 1,  32'h0, 0,        0, 64'h0,  64'h0);
        vecs[6] = mkv(32'h0000_0000, 0,  1,  0, 32'h0, 0,          32'h0, 0,        32'h0, 0,        0, 64'h0,  64'h0);
        vecs[7] = mkv(32'h0000_0000, 5,  11, 1, 32'h0000_0000, 5,  32'h0, 0,        32'h0, 0,        0, 64'h50, 64'h300);
        vecs[8] = mkv(32'h0000_0200, 4,  6,  1, 32'h0000_0200, 4,  32'h0, 0,        32'h0, 0,        2, 64'h0,  64'h0);
        vecs[9] = mkv(32'h0000_0240, 3,  5,  1, 32'h0000_0240, 3,  32'h0, 0,        32'h0, 0,        4, 64'h0,  64'h0);

        fifo_ne = 1'b1;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_avm_write", avm_write, 1'b0);
        check("rst_fifo_re", fifo_re, 1'b0);
        check("rst_avm_address", avm_address, 32'h0);
        check("rst_avm_burstcount", avm_burstcount, 5'd0);
        check("byteenable", avm_byteenable, 4'hF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run(vecs[i], i);

        // Synchronous clear after 3 of 8 beats: burst abandoned, no done, FIFO not popped.
        @(negedge clk);
        addr  = 32'h0;
        len   = 16'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pops = 0;
        for (int c = 0; c < 50 && pops < 3; c++) begin
            #1;
            if (fifo_re) begin
                check("clr_writedata", avm_writedata, 32'hA500_0000 + pop_idx);
                pop_idx++;
                pops++;
            end
            @(negedge clk);
        end
        check("clr_pops_before", pops, 3);
        clr_n = 1'b0;
        #1;
        check("clr_no_pop", fifo_re, 1'b0);
        @(negedge clk);
        clr_n = 1'b1;
        #1;
        check("clr_busy", busy, 1'b0);
        check("clr_avm_write", avm_write, 1'b0);
        check("clr_done", done, 1'b0);
        check("clr_avm_address", avm_address, 32'h0);
        check("clr_avm_burstcount", avm_burstcount, 5'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("clr_no_done_later", done, 1'b0);
        end
        run(mkv(32'h0000_0040, 2, 4, 1, 32'h0000_0040, 2, 32'h0, 0, 32'h0, 0, 0, 64'h0, 64'h0), 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
